// File: rtl/health_tracker_pkg.sv
// Shared round-state encoding and default tuning constants for the health tracker.
package health_tracker_pkg;

  typedef enum logic [1:0] {
    FIGHT       = 2'd0,
    KO          = 2'd1,
    ROUND_RESET = 2'd2
  } round_state_t;

  localparam int DEF_N_PLAYERS    = 2;
  localparam int DEF_HEALTH_W     = 8;
  localparam int DEF_MAX_HEALTH   = 200;
  localparam int DEF_DMG_W        = 6;
  localparam int DEF_IFRAMES      = 30;
  localparam int DEF_REGEN_EN     = 0;
  localparam int DEF_REGEN_PERIOD = 60;
  localparam int DEF_ROUND_HOLD   = 120;

endpackage

// File: rtl/health_tracker_if.sv
// Signal bundle between hit logic / HUD and the health tracker.
interface health_tracker_if #(
  parameter int N_PLAYERS = 2,
  parameter int HEALTH_W  = 8,
  parameter int DMG_W     = 6
);
  import health_tracker_pkg::*;

  // No handshake: every input is a level or pulse sampled on each Clk edge and
  // every output is a registered status that is valid in every cycle.
  logic                          frame_tick;
  logic [N_PLAYERS-1:0]          hit;
  logic [N_PLAYERS*DMG_W-1:0]    damage;
  logic                          round_start;
  logic [N_PLAYERS*HEALTH_W-1:0] health;
  logic [N_PLAYERS-1:0]          invuln;
  logic [N_PLAYERS-1:0]          ko;
  round_state_t                  state;
  logic [N_PLAYERS-1:0]          winner;

  modport master (
    output frame_tick, hit, damage, round_start,
    input  health, invuln, ko, state, winner
  );

  modport slave (
    input  frame_tick, hit, damage, round_start,
    output health, invuln, ko, state, winner
  );

endinterface

// File: rtl/health_tracker_channel.sv
// One fighter: health register, invulnerability timer and regen counter.
module health_tracker_channel #(
  parameter int HEALTH_W     = 8,
  parameter int MAX_HEALTH   = 200,
  parameter int DMG_W        = 6,
  parameter int IFRAMES      = 30,
  parameter int REGEN_EN     = 0,
  parameter int REGEN_PERIOD = 60
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                hit_ok,
  input  logic [DMG_W-1:0]    damage,
  input  logic                frame_tick,
  input  logic                fight,
  input  logic                restore,
  output logic [HEALTH_W-1:0] health,
  output logic                invuln,
  output logic                ko,
  output logic                zero_next
);

  localparam int IF_W = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;
  localparam int RG_W = $clog2(REGEN_PERIOD + 1);

  logic [HEALTH_W-1:0] health_q, health_d;
  logic [IF_W-1:0]     timer_q, timer_d;
  logic [RG_W-1:0]     regen_q, regen_d;
  logic                ko_q;
  logic [HEALTH_W:0]   diff;

  // The extra top bit catches the borrow when damage exceeds remaining health.
  assign diff = {1'b0, health_q} - (HEALTH_W+1)'(damage);

  always_comb begin
    health_d = health_q;
    timer_d  = timer_q;
    regen_d  = regen_q;
    if (restore) begin
      health_d = HEALTH_W'(MAX_HEALTH);
      timer_d  = '0;
      regen_d  = '0;
    end else if (hit_ok) begin
      health_d = diff[HEALTH_W] ? '0 : diff[HEALTH_W-1:0];
      timer_d  = IF_W'(IFRAMES);
      regen_d  = '0;
    end else begin
      if (frame_tick && (timer_q != '0)) timer_d = timer_q - 1'b1;
      if ((REGEN_EN != 0) && fight && frame_tick) begin
        if (regen_q == RG_W'(REGEN_PERIOD - 1)) begin
          regen_d = '0;
          if (!ko_q && (health_q < HEALTH_W'(MAX_HEALTH))) health_d = health_q + 1'b1;
        end else begin
          regen_d = regen_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      health_q <= HEALTH_W'(MAX_HEALTH);
      timer_q  <= '0;
      regen_q  <= '0;
      ko_q     <= 1'b0;
    end else begin
      health_q <= health_d;
      timer_q  <= timer_d;
      regen_q  <= regen_d;
      ko_q     <= restore ? 1'b0 : (health_q == '0);
    end
  end

  assign health    = health_q;
  assign invuln    = (timer_q != '0);
  assign ko        = ko_q;
  assign zero_next = (health_d == '0);

endmodule

// File: rtl/health_tracker.sv
// N-player health tracker: per-player channels plus the FIGHT/KO/ROUND_RESET round FSM.
module health_tracker
  import health_tracker_pkg::*;
#(
  parameter int N_PLAYERS    = DEF_N_PLAYERS,
  parameter int HEALTH_W     = DEF_HEALTH_W,
  parameter int MAX_HEALTH   = DEF_MAX_HEALTH,
  parameter int DMG_W        = DEF_DMG_W,
  parameter int IFRAMES      = DEF_IFRAMES,
  parameter int REGEN_EN     = DEF_REGEN_EN,
  parameter int REGEN_PERIOD = DEF_REGEN_PERIOD,
  parameter int ROUND_HOLD   = DEF_ROUND_HOLD
) (
  input logic             Clk,
  input logic             Reset,
  health_tracker_if.slave bus
);

  localparam int HOLD_W = $clog2(ROUND_HOLD + 1);

  round_state_t                  state_q, state_d;
  logic [N_PLAYERS-1:0]          winner_q, winner_d;
  logic [HOLD_W-1:0]             hold_q, hold_d;
  logic [N_PLAYERS-1:0]          zero_next, hit_ok, invuln_all, ko_all;
  logic [N_PLAYERS*HEALTH_W-1:0] health_all;
  logic                          restore, fight;

  assign fight  = (state_q == FIGHT);
  assign hit_ok = bus.hit & ~invuln_all & {N_PLAYERS{fight}};

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_ch
    health_tracker_channel #(
      .HEALTH_W(HEALTH_W), .MAX_HEALTH(MAX_HEALTH), .DMG_W(DMG_W),
      .IFRAMES(IFRAMES), .REGEN_EN(REGEN_EN), .REGEN_PERIOD(REGEN_PERIOD)
    ) u_ch (
      .Clk        (Clk),
      .Reset      (Reset),
      .hit_ok     (hit_ok[g]),
      .damage     (bus.damage[g*DMG_W +: DMG_W]),
      .frame_tick (bus.frame_tick),
      .fight      (fight),
      .restore    (restore),
      .health     (health_all[g*HEALTH_W +: HEALTH_W]),
      .invuln     (invuln_all[g]),
      .ko         (ko_all[g]),
      .zero_next  (zero_next[g])
    );
  end

  // A KO detected on the same edge as round_start wins; round_start then applies from KO.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    hold_d   = hold_q;
    restore  = 1'b0;
    case (state_q)
      FIGHT: begin
        if (|zero_next) begin
          state_d  = KO;
          winner_d = ~zero_next;
          hold_d   = '0;
        end else if (bus.round_start) begin
          state_d = ROUND_RESET;
        end
      end
      KO: begin
        if (bus.round_start) begin
          state_d = ROUND_RESET;
          hold_d  = '0;
        end else if (bus.frame_tick) begin
          if (hold_q == HOLD_W'(ROUND_HOLD - 1)) begin
            state_d = ROUND_RESET;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      ROUND_RESET: begin
        restore = 1'b1;
        state_d = FIGHT;
        hold_d  = '0;
      end
      default: state_d = FIGHT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= FIGHT;
      winner_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.health = health_all;
  assign bus.invuln = invuln_all;
  assign bus.ko     = ko_all;
  assign bus.state  = state_q;
  assign bus.winner = winner_q;

endmodule

// File: tb/tb_health_tracker.sv
// Bench for health_tracker: directed round scenarios plus random play against a rule-level model.
module tb_health_tracker;
  import health_tracker_pkg::*;

  localparam int N    = 2;
  localparam int HW   = 8;
  localparam int DW   = 6;
  localparam int MAXH = 200;
  localparam int IFR  = 30;
  localparam int REGN = 1;
  localparam int RP   = 60;
  localparam int HOLD = 120;

  // clock / reset
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  health_tracker_if #(.N_PLAYERS(N), .HEALTH_W(HW), .DMG_W(DW)) bus();

  health_tracker #(
    .N_PLAYERS(N), .HEALTH_W(HW), .MAX_HEALTH(MAXH), .DMG_W(DW), .IFRAMES(IFR),
    .REGEN_EN(REGN), .REGEN_PERIOD(RP), .ROUND_HOLD(HOLD)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // reference model: phase 0=FIGHT 1=KO 2=ROUND_RESET
  int m_h[N], m_ifr[N], m_rc[N], m_ko[N];
  int m_phase, m_hold, m_win;
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  oh[N];
    int  dmg;
    bit  any0;
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        m_h[i] = MAXH; m_ifr[i] = 0; m_rc[i] = 0; m_ko[i] = 0;
      end
      m_phase = 0; m_hold = 0; m_win = 0;
      return;
    end
    for (int i = 0; i < N; i++) oh[i] = m_h[i];
    case (m_phase)
      0: begin
        for (int i = 0; i < N; i++) begin
          dmg = int'(bus.damage[i*DW +: DW]);
          if (bus.hit[i] && m_ifr[i] == 0) begin
            m_h[i] = (m_h[i] > dmg) ? m_h[i] - dmg : 0;
            m_ifr[i] = IFR;
            m_rc[i] = 0;
          end else begin
            if (bus.frame_tick && m_ifr[i] > 0) m_ifr[i]--;
            if (REGN != 0 && bus.frame_tick) begin
              m_rc[i]++;
              if (m_rc[i] == RP) begin
                m_rc[i] = 0;
                if (m_ko[i] == 0 && m_h[i] < MAXH) m_h[i]++;
              end
            end
          end
          m_ko[i] = (oh[i] == 0);
        end
        any0 = 0;
        for (int i = 0; i < N; i++) if (m_h[i] == 0) any0 = 1;
        if (any0) begin
          m_phase = 1; m_hold = 0; m_win = 0;
          for (int i = 0; i < N; i++) if (m_h[i] != 0) m_win += (1 << i);
        end else if (bus.round_start) begin
          m_phase = 2;
        end
      end
      1: begin
        for (int i = 0; i < N; i++) begin
          if (bus.frame_tick && m_ifr[i] > 0) m_ifr[i]--;
          m_ko[i] = (oh[i] == 0);
        end
        if (bus.round_start) begin
          m_phase = 2; m_hold = 0;
        end else if (bus.frame_tick) begin
          m_hold++;
          if (m_hold == HOLD) begin m_phase = 2; m_hold = 0; end
        end
      end
      default: begin
        for (int i = 0; i < N; i++) begin
          m_h[i] = MAXH; m_ifr[i] = 0; m_rc[i] = 0; m_ko[i] = 0;
        end
        m_phase = 0; m_hold = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    logic [N*HW-1:0] eh;
    logic [N-1:0]    einv, eko;
    for (int i = 0; i < N; i++) begin
      eh[i*HW +: HW] = HW'(m_h[i]);
      einv[i] = (m_ifr[i] != 0);
      eko[i]  = (m_ko[i] != 0);
    end
    check_eq("health", 32'(bus.health), 32'(eh));
    check_eq("invuln", 32'(bus.invuln), 32'(einv));
    check_eq("ko",     32'(bus.ko),     32'(eko));
    check_eq("state",  32'(bus.state),  32'(m_phase));
    check_eq("winner", 32'(bus.winner), 32'(m_win));
  endtask

  // driver tasks
  task automatic step();
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      bus.frame_tick = 1'b1; step();
      bus.frame_tick = 1'b0; step();
    end
  endtask

  task automatic do_hit(input logic [N-1:0] h, input int d0, input int d1);
    logic [DW-1:0] a, b;
    a = DW'(d0);
    b = DW'(d1);
    bus.hit = h;
    bus.damage = {b, a};
    step();
    bus.hit = '0;
  endtask

  task automatic do_reset();
    Reset = 1'b1; step(); step();
    Reset = 1'b0;
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.hit = '0;
    bus.damage = '0;
    bus.round_start = 1'b0;

    do_reset();
    check_eq("rst_health", 32'(bus.health), 32'({8'd200, 8'd200}));
    check_eq("rst_state", 32'(bus.state), 32'(FIGHT));

    // single hit, iframe window length
    do_hit(2'b01, 20, 0);
    check_eq("t1_health0", 32'(bus.health[7:0]), 32'd180);
    ticks(29);
    check_eq("t1_inv_29", 32'(bus.invuln[0]), 32'd1);
    ticks(1);
    check_eq("t1_inv_30", 32'(bus.invuln[0]), 32'd0);

    // hit during iframes ignored
    do_hit(2'b01, 20, 0);
    ticks(5);
    do_hit(2'b01, 20, 0);
    check_eq("t2_ignored", 32'(bus.health[7:0]), 32'd160);
    ticks(30);
    do_hit(2'b01, 20, 0);
    check_eq("t2_second", 32'(bus.health[7:0]), 32'd140);

    // player 1 KO with saturating damage
    do_reset();
    for (int k = 0; k < 4; k++) begin
      do_hit(2'b10, 0, 63);
      if (k < 3) ticks(31);
    end
    check_eq("t3_health1", 32'(bus.health[15:8]), 32'd0);
    check_eq("t3_state", 32'(bus.state), 32'(KO));
    check_eq("t3_winner", 32'(bus.winner), 32'b01);
    step();
    check_eq("t3_ko1", 32'(bus.ko), 32'b10);

    // hits in KO, then automatic round reset after the hold
    do_hit(2'b11, 63, 63);
    check_eq("t5_ko_hit", 32'(bus.health[7:0]), 32'd200);
    ticks(119);
    check_eq("t5_hold", 32'(bus.state), 32'(KO));
    bus.frame_tick = 1'b1; step(); bus.frame_tick = 1'b0;
    check_eq("t5_rr", 32'(bus.state), 32'(ROUND_RESET));
    step();
    check_eq("t5_fight", 32'(bus.state), 32'(FIGHT));
    check_eq("t5_health", 32'(bus.health), 32'({8'd200, 8'd200}));
    check_eq("t5_winner_kept", 32'(bus.winner), 32'b01);

    // simultaneous zeroing is a draw
    for (int k = 0; k < 4; k++) begin
      do_hit(2'b11, 63, 63);
      if (k < 3) ticks(31);
    end
    check_eq("t4_state", 32'(bus.state), 32'(KO));
    check_eq("t4_draw", 32'(bus.winner), 32'b00);
    bus.round_start = 1'b1; step(); bus.round_start = 1'b0;
    check_eq("t4_rs", 32'(bus.state), 32'(ROUND_RESET));
    step();

    // regen step, hit beating regen, reset mid-KO
    do_reset();
    do_hit(2'b01, 63, 0);
    ticks(31);
    do_hit(2'b01, 37, 0);
    check_eq("t6_100", 32'(bus.health[7:0]), 32'd100);
    ticks(60);
    check_eq("t6_regen", 32'(bus.health[7:0]), 32'd101);
    ticks(59);
    bus.frame_tick = 1'b1;
    do_hit(2'b01, 5, 0);
    bus.frame_tick = 1'b0;
    check_eq("t6_hit_wins", 32'(bus.health[7:0]), 32'd96);
    for (int k = 0; k < 4; k++) begin
      do_hit(2'b10, 0, 63);
      if (k < 3) ticks(31);
    end
    check_eq("t6_ko", 32'(bus.state), 32'(KO));
    Reset = 1'b1; step(); Reset = 1'b0;
    check_eq("t6_rst_state", 32'(bus.state), 32'(FIGHT));
    check_eq("t6_rst_health", 32'(bus.health), 32'({8'd200, 8'd200}));

    // random play
    for (int c = 0; c < 6000; c++) begin
      bus.frame_tick  = ($urandom_range(0, 2) == 0);
      bus.hit         = ($urandom_range(0, 5) == 0) ? N'($urandom_range(1, 3)) : '0;
      bus.damage      = (N*DW)'($urandom);
      bus.round_start = ($urandom_range(0, 399) == 0);
      Reset           = ($urandom_range(0, 2999) == 0);
      step();
    end
    Reset = 1'b0;
    bus.hit = '0;
    bus.round_start = 1'b0;
    bus.frame_tick = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
